forward_activate: RTL and testbench
===================================

Name: forward_activate

Overview:
- Layer-output stage directly downstream of the forward multiply-accumulate stage; consumes its primary accumulator vector (NC signed sums, width WA each).
- Per neuron: ReLU, arithmetic right shift by SHIFT, saturation back to WV bits. Result is the next layer's State vector.
- In TRAIN mode also emits an NC-bit ReLU-derivative mask for the backward path.
- Two outputs with independent ready; each accepted vector is delivered exactly once on each enabled output.

Parameters:
- NP, 7, fan-in of the producing layer; sets accumulator width WA = $clog2(NP)+1+WV
- NC, 11, number of neurons (vector elements)
- WV, 5, signed value width of output state elements
- SHIFT, 0, arithmetic right shift applied after ReLU (fixed-point realignment), 0..WA-1
- BURST, "yes", "yes" = 2-entry buffer, full throughput; "no" = 1-entry buffer, at most one accept per two cycles

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous, active-high reset
- iMode  in  1  TRAIN/TEST, sampled per vector at acceptance
- iValid_AM_Accum  in  1  accumulator vector valid
- oReady_AM_Accum  out  1  accumulator vector ready
- iData_AM_Accum  in  NC*WA  signed sums; element i at [i*WA +: WA]
- oValid_BM_State  out  1  state vector valid
- iReady_BM_State  in  1  state vector ready
- oData_BM_State  out  NC*WV  activated state; element i at [i*WV +: WV]
- oValid_BM_Mask  out  1  derivative mask valid (TRAIN only)
- iReady_BM_Mask  in  1  derivative mask ready
- oData_BM_Mask  out  NC  bit i = 1 iff accum element i > 0

Behaviour:
- Interface: one clock (iCLK); reset iRST is synchronous and active-high.
- Transfers: a transfer occurs on valid&&ready at a rising edge. Valid, once raised, holds with stable data until the transfer.
- Element function (combinational, applied before buffering):
  - a = accum element (signed WA).
  - r = (a > 0) ? a : 0.
  - s = r >>> SHIFT.
  - out = min(s, 2^(WV-1)-1), truncated to WV.
  - mask bit = (a > 0). A zero input gives 0 and mask 0.
- Buffer entries: each holds {state, mask, doneS, doneM}.
  - On accept, doneS=0.
  - doneM = 0 if the sampled iMode==TRAIN, else 1.
- Outputs:
  - oValid_BM_State = head valid && !doneS.
  - oValid_BM_Mask = head valid && !doneM.
  - Data shown is always the head entry.
  - Transfer on an output sets that output's done flag.
  - The head retires on the cycle both flags are set, or would be set by that cycle's transfers.
  - Both outputs may transfer in the same cycle.
- Ordering: the outputs never reorder. The mask of vector k is never shown after state k+1 has become visible for it.
- Latency: 1 cycle from accept to the first cycle outputs are valid.
- BURST="yes":
  - oReady_AM_Accum = !full; depth 2.
  - Accept while full is allowed only if the head retires that cycle. oReady is registered, so full means not ready even if the head retires.
  - Sustained throughput is 1 vector/cycle when both readies are held high.
- BURST="no":
  - Depth 1; oReady_AM_Accum = empty.
  - Sustained throughput is 1 vector per 2 cycles.
- Mode:
  - iMode is sampled per entry at acceptance. Changing iMode mid-flight does not affect queued entries.
  - In TEST mode, oValid_BM_Mask stays 0 for that entry and iReady_BM_Mask is ignored.
- Reset:
  - All entries invalid; all done flags cleared.
  - oValid_BM_State=0, oValid_BM_Mask=0.
  - oReady_AM_Accum=0 during the reset cycle, 1 from the first cycle after.
  - Data outputs reset to 0.
  - Reset mid-transfer discards buffered vectors; no partial delivery resumes.
- Boundaries:
  - Empty: no output valid.
  - Full with a stalled output: input backpressured indefinitely, no data loss.
  - Saturation: values at or above 2^(WV-1)<<SHIFT clamp to 2^(WV-1)-1.
  - Most-negative accum gives 0.

Decomposition:
- Shared parameter header:
  - TRAIN/TEST mode encodings via the existing mode-parameter declaration macro.
  - BURST string values.
  - WA derivation expression for reuse by neighbouring stages.
- Sub-module activate_element: combinational, one element, parameters WA/WV/SHIFT. Inputs a; outputs out, mask.
  - Instantiated NC times in a generate loop.
  - Buffer/handshake control stays in forward_activate.

Test Plan:
- Mapping: NP=7, NC=3, WV=5 (WA=9), SHIFT=0, TRAIN, readies high.
  - Input elements {-20, 7, 100} -> state {0, 7, 15}, mask 3'b110. Outputs valid exactly 1 cycle after accept.
- TEST mode, same vector -> state {0, 7, 15} delivered once.
  - oValid_BM_Mask never asserts.
  - Next vector accepted without any iReady_BM_Mask.
- Split acceptance: iReady_BM_State=1, iReady_BM_Mask=0 for 5 cycles, then 1.
  - State transfers once at cycle 1.
  - Mask transfers at cycle 6.
  - Head retires then.
  - Second queued vector appears next cycle.
  - oReady low while the 2 entries are held.
- Throughput, BURST="yes": 10 back-to-back vectors, readies high -> 10 outputs on consecutive cycles, in order.
  - BURST="no" with the same stimulus -> outputs every 2nd cycle.
- SHIFT=2 boundaries: accum 0 -> 0, mask 0. Accum 3 -> 0, mask 1. Accum 63 -> 15. Accum 64 -> 15 (saturated). Accum -256 -> 0.
- Reset with 2 entries buffered and outputs stalled: assert iRST 1 cycle -> all valids 0 next cycle, oReady 1 the cycle after, no stale vector ever emitted.

Source files
------------

// File: rtl/forward_activate_pkg.sv
// Shared definitions for the forward activation stage and its neighbouring stages:
// mode encodings, buffer-style selectors and the accumulator width rule.
package forward_activate_pkg;

   typedef enum logic {
      MODE_TEST  = 1'b0,
      MODE_TRAIN = 1'b1
   } mode_e;

   localparam string BURST_YES = "yes";
   localparam string BURST_NO  = "no";

   // Accumulator width for a fan-in of np products of wv-bit values.
   function automatic int fa_wa_width(input int np, input int wv);
      return $clog2(np) + 1 + wv;
   endfunction

endpackage

// File: rtl/activate_element.sv
// One neuron: ReLU, right shift and saturation to WV bits, plus the ReLU derivative bit.
// Purely combinational; no handshake.
module activate_element #(
   parameter int WA    = 9,
   parameter int WV    = 5,
   parameter int SHIFT = 0
) (
   input  logic signed [WA-1:0] a,
   output logic        [WV-1:0] out,
   output logic                 mask
);

   localparam logic [WA-1:0] SAT = WA'((1 << (WV - 1)) - 1);

   logic [WA-1:0] r;
   logic [WA-1:0] s;

   always_comb begin
      mask = !a[WA-1] && (a != '0);
      r    = mask ? a : '0;
      // r is never negative here, so a logical shift equals the arithmetic one
      s    = r >> SHIFT;
      out  = (s > SAT) ? SAT[WV-1:0] : s[WV-1:0];
   end

endmodule

// File: rtl/forward_activate.sv
// Activates the accumulator vector into the next State vector (and TRAIN-mode derivative mask).
// Latency 1 cycle; 2-entry (BURST) or 1-entry buffer, registered ready, outputs drain independently.
module forward_activate
   import forward_activate_pkg::*;
#(
   parameter int    NP    = 7,
   parameter int    NC    = 11,
   parameter int    WV    = 5,
   parameter int    SHIFT = 0,
   parameter string BURST = BURST_YES,
   localparam int   WA    = fa_wa_width(NP, WV)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iMode,
   input  logic             iValid_AM_Accum,
   output logic             oReady_AM_Accum,
   input  logic [NC*WA-1:0] iData_AM_Accum,
   output logic             oValid_BM_State,
   input  logic             iReady_BM_State,
   output logic [NC*WV-1:0] oData_BM_State,
   output logic             oValid_BM_Mask,
   input  logic             iReady_BM_Mask,
   output logic [NC-1:0]    oData_BM_Mask
);

   localparam bit IS_BURST = (BURST == BURST_YES);

   typedef struct packed {
      logic             vld;
      logic [NC*WV-1:0] st;
      logic [NC-1:0]    mk;
      logic             ds;
      logic             dm;
   } entry_t;

   entry_t           head_q, head_d;
   entry_t           tail_q, tail_d;
   entry_t           fresh;
   logic             rdy_q, rdy_d;
   logic [NC*WV-1:0] act_st;
   logic [NC-1:0]    act_mk;
   logic             xfer_s, xfer_m, retire, accept;

   for (genvar i = 0; i < NC; i++) begin : g_elem
      activate_element #(
         .WA    (WA),
         .WV    (WV),
         .SHIFT (SHIFT)
      ) u_elem (
         .a    (iData_AM_Accum[i*WA +: WA]),
         .out  (act_st[i*WV +: WV]),
         .mask (act_mk[i])
      );
   end

   always_comb begin
      xfer_s   = head_q.vld && !head_q.ds && iReady_BM_State;
      xfer_m   = head_q.vld && !head_q.dm && iReady_BM_Mask;
      retire   = head_q.vld && (head_q.ds || xfer_s) && (head_q.dm || xfer_m);
      accept   = iValid_AM_Accum && rdy_q;

      fresh     = '0;
      fresh.vld = 1'b1;
      fresh.st  = act_st;
      fresh.mk  = act_mk;
      fresh.dm  = !(iMode == MODE_TRAIN);

      head_d    = head_q;
      tail_d    = tail_q;
      head_d.ds = head_q.ds | xfer_s;
      head_d.dm = head_q.dm | xfer_m;
      if (retire) begin
         head_d = tail_q;
         tail_d = '0;
      end
      // A new vector lands in the first slot left free after this cycle's retire
      if (accept) begin
         if (!head_d.vld) begin
            head_d = fresh;
         end else if (IS_BURST) begin
            tail_d = fresh;
         end
      end

      rdy_d = IS_BURST ? !(head_d.vld && tail_d.vld) : !head_d.vld;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         head_q <= '0;
         tail_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         rdy_q  <= rdy_d;
      end
   end

   assign oReady_AM_Accum = rdy_q;
   assign oValid_BM_State = head_q.vld && !head_q.ds;
   assign oValid_BM_Mask  = head_q.vld && !head_q.dm;
   assign oData_BM_State  = head_q.st;
   assign oData_BM_Mask   = head_q.mk;

endmodule

// File: tb/tb_forward_activate.sv
// Three instances (burst/shift0, single-entry/shift0, burst/shift2) driven by directed and random
// steps; a queue scoreboard built from the activation rules checks every delivered vector.
module tb_forward_activate;
   import forward_activate_pkg::*;

   logic             clk;
   logic             rst;
   logic [2:0]       vin, mode_in, rdy_s, rdy_m;
   logic [2:0][26:0] din;
   logic [2:0]       rdy_o, vs_o, vm_o;
   logic [2:0][14:0] st_o;
   logic [2:0][2:0]  mk_o;

   int checks = 0;
   int errors = 0;

   logic [14:0] exp_s [3][$];
   logic [2:0]  exp_m [3][$];

   forward_activate #(.NP(7), .NC(3), .WV(5), .SHIFT(0), .BURST(BURST_YES)) u_a (
      .iCLK(clk), .iRST(rst), .iMode(mode_in[0]),
      .iValid_AM_Accum(vin[0]), .oReady_AM_Accum(rdy_o[0]), .iData_AM_Accum(din[0]),
      .oValid_BM_State(vs_o[0]), .iReady_BM_State(rdy_s[0]), .oData_BM_State(st_o[0]),
      .oValid_BM_Mask(vm_o[0]), .iReady_BM_Mask(rdy_m[0]), .oData_BM_Mask(mk_o[0]));

   forward_activate #(.NP(7), .NC(3), .WV(5), .SHIFT(0), .BURST(BURST_NO)) u_b (
      .iCLK(clk), .iRST(rst), .iMode(mode_in[1]),
      .iValid_AM_Accum(vin[1]), .oReady_AM_Accum(rdy_o[1]), .iData_AM_Accum(din[1]),
      .oValid_BM_State(vs_o[1]), .iReady_BM_State(rdy_s[1]), .oData_BM_State(st_o[1]),
      .oValid_BM_Mask(vm_o[1]), .iReady_BM_Mask(rdy_m[1]), .oData_BM_Mask(mk_o[1]));

   forward_activate #(.NP(7), .NC(3), .WV(5), .SHIFT(2), .BURST(BURST_YES)) u_c (
      .iCLK(clk), .iRST(rst), .iMode(mode_in[2]),
      .iValid_AM_Accum(vin[2]), .oReady_AM_Accum(rdy_o[2]), .iData_AM_Accum(din[2]),
      .oValid_BM_State(vs_o[2]), .iReady_BM_State(rdy_s[2]), .oData_BM_State(st_o[2]),
      .oValid_BM_Mask(vm_o[2]), .iReady_BM_Mask(rdy_m[2]), .oData_BM_Mask(mk_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [26:0] pack3(input int e0, input int e1, input int e2);
      logic [8:0] a0, a1, a2;
      a0 = 9'(e0);
      a1 = 9'(e1);
      a2 = 9'(e2);
      return {a2, a1, a0};
   endfunction

   // Reference: ReLU, divide by 2^sh, clamp to 15; mask is "element is positive"
   function automatic logic [14:0] ref_state(input logic [26:0] v, input int sh);
      logic [14:0] r;
      int          a, val;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         a   = int'($signed(v[i*9 +: 9]));
         val = (a <= 0) ? 0 : a / (2 ** sh);
         if (val > 15) val = 15;
         r[i*5 +: 5] = val[4:0];
      end
      return r;
   endfunction

   function automatic logic [2:0] ref_mask(input logic [26:0] v);
      logic [2:0] m;
      for (int i = 0; i < 3; i++) m[i] = int'($signed(v[i*9 +: 9])) > 0;
      return m;
   endfunction

   function automatic int shift_of(input int d);
      return (d == 2) ? 2 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable at the falling edge, so what is seen here transfers next rise
   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            exp_s[d].delete();
            exp_m[d].delete();
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (vs_o[d] && rdy_s[d]) begin
               checks++;
               assert (exp_s[d].size() != 0)
               else begin
                  errors++;
                  $error("FAIL sb_state_spurious dut%0d: observed valid expected idle", d);
               end
               if (exp_s[d].size() != 0) begin
                  logic [14:0] e;
                  e = exp_s[d].pop_front();
                  checks++;
                  assert (st_o[d] === e)
                  else begin
                     errors++;
                     $error("FAIL sb_state dut%0d: observed %0h expected %0h", d, st_o[d], e);
                  end
               end
            end
            if (vm_o[d] && rdy_m[d]) begin
               checks++;
               assert (exp_m[d].size() != 0)
               else begin
                  errors++;
                  $error("FAIL sb_mask_spurious dut%0d: observed valid expected idle", d);
               end
               if (exp_m[d].size() != 0) begin
                  logic [2:0] e;
                  e = exp_m[d].pop_front();
                  checks++;
                  assert (mk_o[d] === e)
                  else begin
                     errors++;
                     $error("FAIL sb_mask dut%0d: observed %0h expected %0h", d, mk_o[d], e);
                  end
               end
            end
            if (vin[d] && rdy_o[d]) begin
               exp_s[d].push_back(ref_state(din[d], shift_of(d)));
               if (mode_in[d] == MODE_TRAIN) exp_m[d].push_back(ref_mask(din[d]));
            end
         end
      end
   end

   initial begin
      logic [26:0] tv [10];
      logic        tm [10];
      int          sent [2];
      int          got [2];
      int          first [2];
      int          last [2];
      logic [2:0]  acc;

      rst = 1'b1; vin = '0; mode_in = '0; rdy_s = '0; rdy_m = '0; din = '0;
      step();
      check("reset_vs", 32'(vs_o), 0);
      check("reset_vm", 32'(vm_o), 0);
      check("reset_rdy", 32'(rdy_o), 0);
      check("reset_state", 32'(st_o[0]), 0);
      check("reset_mask", 32'(mk_o[0]), 0);
      step();
      rst = 1'b0;
      step();
      check("ready_after_reset", 32'(rdy_o), 32'h7);

      // Mapping, TRAIN
      rdy_s = 3'b111; rdy_m = 3'b111;
      vin[0] = 1'b1; mode_in[0] = MODE_TRAIN; din[0] = pack3(-20, 7, 100);
      check("empty_no_valid", 32'(vs_o[0]), 0);
      step();
      vin[0] = 1'b0;
      check("map_vs", 32'(vs_o[0]), 1);
      check("map_vm", 32'(vm_o[0]), 1);
      check("map_state", 32'(st_o[0]), 32'({5'd15, 5'd7, 5'd0}));
      check("map_mask", 32'(mk_o[0]), 32'b110);
      step();
      check("map_done_vs", 32'(vs_o[0]), 0);
      check("map_done_vm", 32'(vm_o[0]), 0);

      // TEST mode: mask never offered, mask ready ignored
      rdy_m[0] = 1'b0; mode_in[0] = MODE_TEST; vin[0] = 1'b1;
      step();
      vin[0] = 1'b0;
      check("test_vs", 32'(vs_o[0]), 1);
      check("test_vm", 32'(vm_o[0]), 0);
      check("test_state", 32'(st_o[0]), 32'({5'd15, 5'd7, 5'd0}));
      step();
      check("test_once_vs", 32'(vs_o[0]), 0);
      check("test_once_vm", 32'(vm_o[0]), 0);
      check("test_rdy", 32'(rdy_o[0]), 1);
      vin[0] = 1'b1; din[0] = pack3(1, 2, 3);
      step();
      vin[0] = 1'b0;
      check("test_next_vs", 32'(vs_o[0]), 1);
      check("test_next_state", 32'(st_o[0]), 32'({5'd3, 5'd2, 5'd1}));
      step();
      check("test_next_done", 32'(vs_o[0]), 0);

      // Split acceptance: mask stalled 5 cycles, second vector queued behind
      mode_in[0] = MODE_TRAIN; vin[0] = 1'b1; din[0] = pack3(5, -1, 20);
      step();
      din[0] = pack3(-3, 9, 0);
      check("split_c1_vs", 32'(vs_o[0]), 1);
      check("split_c1_vm", 32'(vm_o[0]), 1);
      check("split_c1_rdy", 32'(rdy_o[0]), 1);
      step();
      vin[0] = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         check($sformatf("split_c%0d_vs", c), 32'(vs_o[0]), 0);
         check($sformatf("split_c%0d_vm", c), 32'(vm_o[0]), 1);
         check($sformatf("split_c%0d_mask", c), 32'(mk_o[0]), 32'b101);
         check($sformatf("split_c%0d_rdy", c), 32'(rdy_o[0]), 0);
         if (c == 6) rdy_m[0] = 1'b1;
         step();
      end
      check("split_v2_vs", 32'(vs_o[0]), 1);
      check("split_v2_vm", 32'(vm_o[0]), 1);
      check("split_v2_state", 32'(st_o[0]), 32'({5'd0, 5'd9, 5'd0}));
      check("split_v2_mask", 32'(mk_o[0]), 32'b010);
      check("split_v2_rdy", 32'(rdy_o[0]), 1);
      step();
      check("split_drained", 32'(vs_o[0] | vm_o[0]), 0);

      // Throughput: same 10 vectors into burst and single-entry instances
      for (int i = 0; i < 10; i++) begin
         tv[i] = 27'($urandom);
         tm[i] = 1'($urandom);
      end
      for (int d = 0; d < 2; d++) begin
         sent[d] = 0; got[d] = 0; first[d] = -1; last[d] = -1;
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int d = 0; d < 2; d++) begin
            if (vs_o[d]) begin
               if (got[d] == 0) first[d] = cyc;
               last[d] = cyc;
               got[d]++;
            end
            vin[d] = (sent[d] < 10);
            if (sent[d] < 10) begin
               din[d]     = tv[sent[d]];
               mode_in[d] = tm[sent[d]];
            end
            if (vin[d] && rdy_o[d]) sent[d]++;
         end
         step();
      end
      vin = '0;
      check("tp_burst_count", 32'(got[0]), 10);
      check("tp_burst_first", 32'(first[0]), 1);
      check("tp_burst_span", 32'(last[0] - first[0]), 9);
      check("tp_single_count", 32'(got[1]), 10);
      check("tp_single_span", 32'(last[1] - first[1]), 18);

      // SHIFT=2 boundaries
      vin[2] = 1'b1; mode_in[2] = MODE_TRAIN; din[2] = pack3(0, 3, 63);
      step();
      din[2] = pack3(64, -256, 1);
      check("sh_a_state", 32'(st_o[2]), 32'({5'd15, 5'd0, 5'd0}));
      check("sh_a_mask", 32'(mk_o[2]), 32'b110);
      step();
      vin[2] = 1'b0;
      check("sh_b_state", 32'(st_o[2]), 32'({5'd0, 5'd0, 5'd15}));
      check("sh_b_mask", 32'(mk_o[2]), 32'b101);
      step();

      // Random traffic on all instances with random readies and modes
      acc = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int d = 0; d < 3; d++) begin
            if (!vin[d] || acc[d]) begin
               vin[d]     = ($urandom_range(0, 3) != 0);
               din[d]     = 27'($urandom);
               mode_in[d] = 1'($urandom);
            end
         end
         rdy_s = 3'($urandom);
         rdy_m = 3'($urandom);
         acc   = vin & rdy_o;
         step();
      end
      vin = '0; rdy_s = 3'b111; rdy_m = 3'b111;
      for (int c = 0; c < 6; c++) step();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("drain_state_dut%0d", d), 32'(exp_s[d].size()), 0);
         check($sformatf("drain_mask_dut%0d", d), 32'(exp_m[d].size()), 0);
      end

      // Reset with two entries buffered and both outputs stalled
      rdy_s = '0; rdy_m = '0; mode_in[0] = MODE_TRAIN;
      vin[0] = 1'b1; din[0] = pack3(10, 11, 12);
      step();
      din[0] = pack3(13, 14, 15);
      step();
      vin[0] = 1'b0;
      check("pre_rst_full", 32'(rdy_o[0]), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_vs", 32'(vs_o), 0);
      check("rst_vm", 32'(vm_o), 0);
      check("rst_rdy_low", 32'(rdy_o), 0);
      rdy_s = 3'b111; rdy_m = 3'b111;
      step();
      check("rst_rdy_high", 32'(rdy_o), 32'h7);
      for (int c = 0; c < 3; c++) begin
         check("rst_no_stale", 32'(vs_o | vm_o), 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
